// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_sched_pkg
// Description : Shared types and helpers for the UART transmit scheduler:
//               FSM state encoding, counter widths, header-byte builder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

  localparam int TOCNT_W = 8;  // WAIT_ACK timeout counter width
  localparam int BCNT_W  = 4;  // burst payload counter width
  localparam int GCNT_W  = 8;  // inter-byte gap counter width

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_HDR,
    S_RD,
    S_LATCH,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } sched_state_t;

  // Header byte: tag in the upper seven bits, channel number in bit 0.
  function automatic logic [7:0] hdr_byte(input logic [6:0] tag, input logic ch);
    return {tag, ch};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Bundles the FIFO read ports, the transmitter handshake and the
//               scheduler status lines. master = scheduler, slave = FIFOs,
//               transmitter and controlling logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if;

  logic       i_enable;
  logic       ch0_rdempty;
  logic       ch1_rdempty;
  logic [7:0] ch0_q;
  logic [7:0] ch1_q;
  logic       ch0_rdreq;
  logic       ch1_rdreq;
  logic       tx_busy;
  logic       uart_en;
  logic [7:0] paralle_data;
  logic       active_ch;
  logic       busy;
  logic       err_timeout;

  modport master (
    input  i_enable, ch0_rdempty, ch1_rdempty, ch0_q, ch1_q, tx_busy,
    output ch0_rdreq, ch1_rdreq, uart_en, paralle_data, active_ch, busy, err_timeout
  );

  modport slave (
    output i_enable, ch0_rdempty, ch1_rdempty, ch0_q, ch1_q, tx_busy,
    input  ch0_rdreq, ch1_rdreq, uart_en, paralle_data, active_ch, busy, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/uart_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_arb
// Description : Combinational 2-way round-robin arbiter. The channel granted
//               last loses a tie; a lone requester always wins. The last-grant
//               register lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Grant selection: on a tie favour the channel not granted last.
  always_comb begin
    valid_o = en_i & (|req_i);
    gnt_o   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else begin
      gnt_o = req_i[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Transmit scheduler between two byte FIFOs and one serial
//               transmitter. Round-robin burst grants, optional header byte,
//               enable/busy handshake with ACK timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int unsigned BURST_LEN   = 4,
  parameter bit          HDR_EN      = 1'b1,
  parameter logic [6:0]  HDR_TAG     = 7'h55,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic           sysclk_12,
  input  logic           i_rest,
  uart_tx_sched_if.master bus
);

  import uart_sched_pkg::*;

  localparam logic [BCNT_W-1:0]  BURST_MAX = BCNT_W'(BURST_LEN);
  localparam logic [TOCNT_W-1:0] TO_LAST   = TOCNT_W'(ACK_TIMEOUT - 1);
  localparam logic [GCNT_W-1:0]  GAP_LAST  = GCNT_W'(GAP_CYCLES - 1);

  sched_state_t        state_q, state_d;
  logic                active_q, active_d;
  logic                last_q, last_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [TOCNT_W-1:0]  tocnt_q, tocnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic [7:0]          data_q, data_d;
  logic                uart_en_q, uart_en_d;
  logic                err_q, err_d;

  logic                arb_gnt;
  logic                arb_valid;
  logic                act_empty;

  uart_rr_arb u_arb (
    .req_i   ({~bus.ch1_rdempty, ~bus.ch0_rdempty}),
    .last_i  (last_q),
    .en_i    (bus.i_enable),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign act_empty = active_q ? bus.ch1_rdempty : bus.ch0_rdempty;

  // State and datapath registers; everything returns to idle asynchronously.
  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      state_q   <= S_IDLE;
      active_q  <= 1'b0;
      last_q    <= 1'b1;   // ch0 wins the first tie after reset
      bcnt_q    <= '0;
      tocnt_q   <= '0;
      gcnt_q    <= '0;
      data_q    <= 8'h00;
      uart_en_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      tocnt_q   <= tocnt_d;
      gcnt_q    <= gcnt_d;
      data_q    <= data_d;
      uart_en_q <= uart_en_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: burst sequencing, transmitter handshake and timeouts.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    bcnt_d   = bcnt_q;
    tocnt_d  = tocnt_q;
    gcnt_d   = gcnt_q;
    data_d   = data_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_enable && (!bus.ch0_rdempty || !bus.ch1_rdempty)) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (arb_valid) begin
          active_d = arb_gnt;
          bcnt_d   = '0;
          state_d  = HDR_EN ? S_HDR : S_RD;
        end else begin
          // Requests vanished between IDLE and ARB; nothing to grant.
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        data_d  = hdr_byte(HDR_TAG, active_q);
        state_d = S_START;
      end
      S_RD: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        data_d  = active_q ? bus.ch1_q : bus.ch0_q;
        bcnt_d  = bcnt_q + 1'b1;
        state_d = S_START;
      end
      S_START: begin
        tocnt_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tocnt_q >= TO_LAST) begin
          // Transmitter never acknowledged: drop the byte and flag it.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tocnt_q != '1) begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          gcnt_d  = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt_q >= GAP_LAST) begin
          if (bus.i_enable && !act_empty && (bcnt_q < BURST_MAX)) begin
            state_d = S_RD;
          end else begin
            last_d  = active_q;
            state_d = S_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // uart_en is high exactly while the FSM sits in WAIT_ACK.
    uart_en_d = (state_d == S_WAIT_ACK);
  end

  assign bus.ch0_rdreq    = (state_q == S_RD) && !active_q;
  assign bus.ch1_rdreq    = (state_q == S_RD) &&  active_q;
  assign bus.uart_en      = uart_en_q;
  assign bus.paralle_data = data_q;
  assign bus.active_ch    = active_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.err_timeout  = err_q;

endmodule
`default_nettype wire
